pipeline_hazard_ctrl: RTL

//  Hazard and sequencing controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards and flushes the wrong path after taken jumps/branches resolved in EX.
//  - Produces EX-stage forwarding selects.
//  - Sequences start-up and halt-drain of the pipeline.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls, redirect flushes,
// EX-stage forwarding selects, start-up/halt-drain sequencing and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int RA_W      = 3,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_id,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_ldm,
  input  logic             ex_wen,
  input  logic [1:0]       ex_pcSel,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_wen,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_wen,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [DC_W-1:0] drain_cnt;
  logic            redirect;
  logic            load_use;
  logic            stall_event;
  logic            flush_event;
  logic            enter_start;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic [RA_W-1:0] m_rd,
                                         input logic            m_wen,
                                         input logic [RA_W-1:0] w_rd,
                                         input logic            w_wen);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wen && (m_rd == rs))
      sel = 2'b10;
    else if (w_wen && (w_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign redirect = (ex_pcSel != 2'b00);
  assign load_use = ex_ldm && ex_wen &&
                    ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

  // A redirect means the ID instruction is on the wrong path, so it can neither stall nor halt.
  assign stall_event = (state == RUN) && !redirect && load_use;
  assign flush_event = (state == RUN) && redirect;
  assign enter_start = (next_state == START) && (state != START);

  assign fwdA = fwd_sel(ex_rs1, mem_rd, mem_wen, wb_rd, wb_wen);
  assign fwdB = fwd_sel(ex_rs2, mem_rd, mem_wen, wb_rd, wb_wen);

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == RUN && next_state == DRAIN)
        drain_cnt <= DC_W'(DRAIN_CYC - 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DC_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = START;
      START:   if (!start) next_state = RUN;
      RUN:     if (halt_id && !redirect) next_state = DRAIN;
      DRAIN:   if (drain_cnt == '0) next_state = HALTED;
      HALTED:  if (start) next_state = START;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    if (state == RUN) begin
      pc_stall    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else if (halt_id) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  // Counters report activity since the most recent start, so they clear on entering START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (enter_start) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_event && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
